// File: rtl/vote_sequencer.sv
// vote_sequencer: round-robin collection of three votes into one shared
// majority/minority voter, with a per-round timeout that forces missing votes to 0.
`default_nettype none

module vote_sequencer #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic        MINORITY = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] req,
  input  logic [2:0] vote,
  output logic [2:0] gnt,
  output logic       busy,
  output logic       done,
  output logic       y,
  output logic [2:0] votes,
  output logic [2:0] missing,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EVAL    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] captured_q, captured_d;
  logic [2:0] votes_q, votes_d;
  logic [2:0] missing_q, missing_d;
  logic       timeout_q, timeout_d;
  logic       y_q, y_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] rr_q, rr_d;

  logic [2:0] elig;
  logic [2:0] pick;
  logic [2:0] cap_all;
  logic [2:0] votes_cap;

  // Rotating priority starting at rr_q; only uncaptured requesters compete.
  always_comb begin
    elig = req & ~captured_q;
    pick = 3'b000;
    case (rr_q)
      2'd0: begin
        if      (elig[0]) pick = 3'b001;
        else if (elig[1]) pick = 3'b010;
        else if (elig[2]) pick = 3'b100;
      end
      2'd1: begin
        if      (elig[1]) pick = 3'b010;
        else if (elig[2]) pick = 3'b100;
        else if (elig[0]) pick = 3'b001;
      end
      default: begin
        if      (elig[2]) pick = 3'b100;
        else if (elig[0]) pick = 3'b001;
        else if (elig[1]) pick = 3'b010;
      end
    endcase
  end

  assign cap_all   = captured_q | pick;
  assign votes_cap = (votes_q & ~pick) | (vote & pick);

  always_comb begin
    state_d    = state_q;
    captured_d = captured_q;
    votes_d    = votes_q;
    missing_d  = missing_q;
    timeout_d  = timeout_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    gnt        = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_COLLECT;
          captured_d = 3'b000;
          votes_d    = 3'b000;
          missing_d  = 3'b000;
          timeout_d  = 1'b0;
          cnt_d      = 8'd0;
        end
      end
      S_COLLECT: begin
        gnt        = pick;
        votes_d    = votes_cap;
        captured_d = cap_all;
        cnt_d      = cnt_q + 8'd1;
        if (pick[0]) rr_d = 2'd1;
        if (pick[1]) rr_d = 2'd2;
        if (pick[2]) rr_d = 2'd0;
        if (cap_all == 3'b111) begin
          state_d = S_EVAL;
        end else if (cnt_q == TMO_LAST) begin
          // A capture in this final cycle still counts; only the rest are forced.
          state_d   = S_EVAL;
          votes_d   = votes_cap & cap_all;
          missing_d = ~cap_all;
          timeout_d = 1'b1;
        end
      end
      S_EVAL: begin
        y_d     = MINORITY ^ ((votes_q[0] & votes_q[1]) |
                              (votes_q[0] & votes_q[2]) |
                              (votes_q[1] & votes_q[2]));
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      captured_q <= 3'b000;
      votes_q    <= 3'b000;
      missing_q  <= 3'b000;
      timeout_q  <= 1'b0;
      y_q        <= 1'b0;
      cnt_q      <= 8'd0;
      rr_q       <= 2'd0;
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
      votes_q    <= votes_d;
      missing_q  <= missing_d;
      timeout_q  <= timeout_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign y       = y_q;
  assign votes   = votes_q;
  assign missing = missing_q;
  assign timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_vote_sequencer.sv
// tb_vote_sequencer: scoreboard bench; majority and minority instances share all inputs.
`default_nettype none

module tb_vote_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] req;
  logic [2:0] vote;

  logic [2:0] gnt0, votes0, missing0;
  logic       busy0, done0, y0, timeout0;
  logic [2:0] gnt1, votes1, missing1;
  logic       busy1, done1, y1, timeout1;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int saved;

  // {y_majority, y_minority, votes[2:0], missing[2:0], timeout}
  logic [8:0] sb[$];

  vote_sequencer #(.TIMEOUT(15), .MINORITY(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .req(req), .vote(vote),
    .gnt(gnt0), .busy(busy0), .done(done0), .y(y0),
    .votes(votes0), .missing(missing0), .timeout(timeout0)
  );

  vote_sequencer #(.TIMEOUT(15), .MINORITY(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .req(req), .vote(vote),
    .gnt(gnt1), .busy(busy1), .done(done1), .y(y1),
    .votes(votes1), .missing(missing1), .timeout(timeout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] v, input logic [2:0] mask);
    logic [2:0] ev;
    logic       maj;
    ev  = v & mask;
    maj = (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);
    sb.push_back({maj, ~maj, ev, ~mask, (mask != 3'b111)});
  endtask

  task automatic drive(input logic s, input logic [2:0] r, input logic [2:0] v);
    start = s;
    req   = r;
    vote  = v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_chk(input string tag, input logic [2:0] eg, input logic eb, input logic ed);
    #1;
    check_eq({tag, "_gnt"},  gnt0,  eg);
    check_eq({tag, "_busy"}, busy0, eb);
    check_eq({tag, "_done"}, done0, ed);
    next_cycle();
  endtask

  task automatic chk_reset(input string tag);
    check_eq({tag, "_gnt"},     gnt0,     3'b000);
    check_eq({tag, "_busy"},    busy0,    1'b0);
    check_eq({tag, "_done"},    done0,    1'b0);
    check_eq({tag, "_y0"},      y0,       1'b0);
    check_eq({tag, "_y1"},      y1,       1'b0);
    check_eq({tag, "_votes"},   votes0,   3'b000);
    check_eq({tag, "_missing"}, missing0, 3'b000);
    check_eq({tag, "_timeout"}, timeout0, 1'b0);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy0 && n < limit) begin
      next_cycle();
      n++;
    end
    check_eq("idle_wait", busy0, 1'b0);
  endtask

  task automatic run_round(input logic [2:0] r, input logic [2:0] v, input logic [2:0] mask);
    drive(1'b1, r, v);
    push_exp(v, mask);
    next_cycle();
    drive(1'b0, r, v);
    wait_idle(40);
  endtask

  always @(negedge clk) begin
    if (done0) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check_eq("sb_depth", sb.size(), 1);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check_eq("res_y_maj",   y0,       e[8]);
        check_eq("res_y_min",   y1,       e[7]);
        check_eq("res_votes",   votes0,   e[6:4]);
        check_eq("res_missing", missing0, e[3:1]);
        check_eq("res_timeout", timeout0, e[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'b000, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    reset = 1'b0;
    next_cycle();

    // Full round, rr_ptr=0.
    drive(1'b1, 3'b111, 3'b101);
    push_exp(3'b101, 3'b111);
    cyc_chk("full_c0", 3'b000, 1'b0, 1'b0);
    drive(1'b0, 3'b111, 3'b101);
    cyc_chk("full_c1", 3'b001, 1'b1, 1'b0);
    cyc_chk("full_c2", 3'b010, 1'b1, 1'b0);
    cyc_chk("full_c3", 3'b100, 1'b1, 1'b0);
    cyc_chk("full_c4", 3'b000, 1'b1, 1'b0);
    cyc_chk("full_c5", 3'b000, 1'b1, 1'b1);
    cyc_chk("full_c6", 3'b000, 1'b0, 1'b0);

    // Fairness: late requester 0 is served last.
    drive(1'b1, 3'b110, 3'b011);
    push_exp(3'b011, 3'b111);
    cyc_chk("fair_c0", 3'b000, 1'b0, 1'b0);
    drive(1'b0, 3'b110, 3'b011);
    cyc_chk("fair_c1", 3'b010, 1'b1, 1'b0);
    cyc_chk("fair_c2", 3'b100, 1'b1, 1'b0);
    drive(1'b0, 3'b111, 3'b011);
    cyc_chk("fair_c3", 3'b001, 1'b1, 1'b0);
    cyc_chk("fair_c4", 3'b000, 1'b1, 1'b0);
    cyc_chk("fair_c5", 3'b000, 1'b1, 1'b1);
    drive(1'b0, 3'b000, 3'b000);
    cyc_chk("fair_c6", 3'b000, 1'b0, 1'b0);

    // Majority vs minority on a few patterns.
    run_round(3'b111, 3'b011, 3'b111);
    run_round(3'b111, 3'b001, 3'b111);
    run_round(3'b111, 3'b110, 3'b111);
    run_round(3'b111, 3'b000, 3'b111);

    // Timeout with only requester 0 active.
    drive(1'b1, 3'b001, 3'b001);
    push_exp(3'b001, 3'b001);
    cyc_chk("tmo_c0", 3'b000, 1'b0, 1'b0);
    drive(1'b0, 3'b001, 3'b001);
    cyc_chk("tmo_c1", 3'b001, 1'b1, 1'b0);
    repeat (13) next_cycle();
    cyc_chk("tmo_c15", 3'b000, 1'b1, 1'b0);
    cyc_chk("tmo_c16", 3'b000, 1'b1, 1'b0);
    cyc_chk("tmo_c17", 3'b000, 1'b1, 1'b1);
    cyc_chk("tmo_c18", 3'b000, 1'b0, 1'b0);

    // Capture on the final COLLECT cycle counts as captured.
    drive(1'b1, 3'b000, 3'b111);
    push_exp(3'b111, 3'b100);
    cyc_chk("last_c0", 3'b000, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 3'b111);
    repeat (14) next_cycle();
    drive(1'b0, 3'b100, 3'b111);
    cyc_chk("last_c15", 3'b100, 1'b1, 1'b0);
    drive(1'b0, 3'b000, 3'b111);
    cyc_chk("last_c16", 3'b000, 1'b1, 1'b0);
    cyc_chk("last_c17", 3'b000, 1'b1, 1'b1);
    cyc_chk("last_c18", 3'b000, 1'b0, 1'b0);

    // Silent round: everything forced.
    run_round(3'b000, 3'b111, 3'b000);

    // Reset mid-COLLECT aborts the round and restarts rr_ptr at 0.
    saved = done_cnt;
    drive(1'b1, 3'b111, 3'b111);
    cyc_chk("abort_c0", 3'b000, 1'b0, 1'b0);
    drive(1'b0, 3'b111, 3'b111);
    cyc_chk("abort_c1", 3'b001, 1'b1, 1'b0);
    #1;
    check_eq("abort_pre_votes", votes0, 3'b001);
    reset = 1'b1;
    #1;
    chk_reset("abort");
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 3'b000, 3'b000);
    next_cycle();
    next_cycle();
    check_eq("abort_no_done", done_cnt, saved);
    drive(1'b1, 3'b111, 3'b110);
    push_exp(3'b110, 3'b111);
    cyc_chk("post_c0", 3'b000, 1'b0, 1'b0);
    drive(1'b0, 3'b111, 3'b110);
    cyc_chk("post_c1", 3'b001, 1'b1, 1'b0);
    cyc_chk("post_c2", 3'b010, 1'b1, 1'b0);
    cyc_chk("post_c3", 3'b100, 1'b1, 1'b0);
    wait_idle(20);

    // start held through cycle 5 runs exactly one round.
    saved = done_cnt;
    drive(1'b1, 3'b111, 3'b100);
    push_exp(3'b100, 3'b111);
    cyc_chk("hold_c0", 3'b000, 1'b0, 1'b0);
    cyc_chk("hold_c1", 3'b001, 1'b1, 1'b0);
    cyc_chk("hold_c2", 3'b010, 1'b1, 1'b0);
    cyc_chk("hold_c3", 3'b100, 1'b1, 1'b0);
    cyc_chk("hold_c4", 3'b000, 1'b1, 1'b0);
    cyc_chk("hold_c5", 3'b000, 1'b1, 1'b1);
    drive(1'b0, 3'b111, 3'b100);
    cyc_chk("hold_c6", 3'b000, 1'b0, 1'b0);
    cyc_chk("hold_c7", 3'b000, 1'b0, 1'b0);
    check_eq("hold_one_round", done_cnt, saved + 1);

    // start still high in cycle 6 launches a second round.
    saved = done_cnt;
    drive(1'b1, 3'b111, 3'b111);
    push_exp(3'b111, 3'b111);
    push_exp(3'b111, 3'b111);
    cyc_chk("back_c0", 3'b000, 1'b0, 1'b0);
    repeat (5) next_cycle();
    cyc_chk("back_c6", 3'b000, 1'b0, 1'b0);
    drive(1'b0, 3'b111, 3'b111);
    cyc_chk("back_c7", 3'b001, 1'b1, 1'b0);
    wait_idle(20);
    check_eq("back_two_rounds", done_cnt, saved + 2);

    check_eq("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
